// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: BYTES_PER_CYCLE S-box lookups per clock.
// Define INV_SUB_BYTES_FWD_EN to add dir_fwd and a forward S-box.
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         dir_fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int B = BYTES_PER_CYCLE;
  localparam int NCHUNK = 16 / B;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int W = 8 * B;

  if (B != 1 && B != 2 && B != 4 && B != 8 && B != 16) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Row 0 sits at the MSB end, so entry x lives at packed index ~x.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  localparam logic [255:0][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic fwd_q;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [127:0] work_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0] chunk_in;
  logic [W-1:0] chunk_out;
  logic accept;
  logic last;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign last = (cnt_q == CW'(NCHUNK - 1));
  assign chunk_in = work_q[int'(cnt_q)*W +: W];
  assign out_data = work_q;

  for (genvar j = 0; j < B; j++) begin : g_sbox
    logic [7:0] b;
    assign b = chunk_in[8*j +: 8];
`ifdef INV_SUB_BYTES_FWD_EN
    assign chunk_out[8*j +: 8] =
      fwd_q ? FWD_SBOX[~b] : INV_SBOX[~b];
`else
    assign chunk_out[8*j +: 8] = INV_SBOX[~b];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_ready = 1'b0;
    busy = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q <= 1'b0;
`endif
    end else if (accept) begin
      work_q <= in_data;
      cnt_q <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q <= dir_fwd;
`endif
    end else if (state_q == S_BUSY) begin
      work_q[int'(cnt_q)*W +: W] <= chunk_out;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule
